// File: rtl/shared_pkg.sv
// ============================================================================
//  Module      : shared_pkg
//  Description : Shared UART definitions (data width, FSM states, parity modes)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_pkg;

    localparam int DATA_WIDTH  = 8;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_states_e;

    // Odd mode makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter; bit_tick marks the last clock of a period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, valid/ready input, start/data/parity/stop frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import shared_pkg::*;
#(
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1,
    parameter int START_BITS   = 2,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BIT_MAX   = (DATA_WIDTH > START_BITS) ? DATA_WIDTH : START_BITS;
    localparam int BIT_CNT_W = $clog2(BIT_MAX + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_DATA  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_START = BIT_CNT_W'(START_BITS - 1);
    localparam logic [1:0]           LAST_STOP  = 2'(STOP_BITS - 1);

    uart_states_e          r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [1:0]            r_stop_cnt;
    logic                  r_tx;
    logic                  r_done;

    logic w_bit_tick;
    logic w_restart;
    logic w_accept;

    assign tx_ready  = (r_state == IDLE) && !rst;
    assign tx_busy   = (r_state != IDLE);
    assign tx        = r_tx;
    assign tx_done   = r_done;
    assign w_accept  = tx_valid && tx_ready;

    // Every other state is entered on a tick, which already wraps the counter.
    assign w_restart = (r_state == IDLE) || (r_state == DONE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (w_restart),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_shift   <= tx_data;
                        r_parity  <= parity_bit(tx_data, PARITY_EN);
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == LAST_START) begin
                            r_bit_cnt <= '0;
                            r_tx      <= r_shift[0];
                            r_state   <= DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == LAST_DATA) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != PARITY_NONE) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= '0;
                                r_state    <= STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= '0;
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Three uart_tx configurations with cycle-exact line monitors
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [2:0] valid_l;
    logic [7:0] data_l [3];
    wire  [2:0] ready_w;
    wire  [2:0] tx_w;
    wire  [2:0] busy_w;
    wire  [2:0] done_w;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instance 0: defaults. 1: odd parity. 2: even parity, 2 stop bits, 4 clks/bit.
    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int P   = (i == 0) ? 0 : (i == 1) ? 1 : 2;
        localparam int SB  = (i == 2) ? 2 : 1;
        localparam int CPB = (i == 2) ? 4 : 1;

        int done_cnt = 0;

        uart_tx #(
            .PARITY_EN    (P),
            .STOP_BITS    (SB),
            .START_BITS   (2),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_data  (data_l[i]),
            .tx_valid (valid_l[i]),
            .tx_ready (ready_w[i]),
            .tx       (tx_w[i]),
            .tx_busy  (busy_w[i]),
            .tx_done  (done_w[i])
        );

        initial forever begin
            @(posedge clk);
            if (done_w[i] === 1'b1) done_cnt++;
        end

        // Scoreboard consumer: pops the expected word at acceptance and checks every line cycle.
        initial begin : mon
            logic [7:0]  w;
            logic [31:0] seq;
            int          np;
            bit          abort;
            bit          exp_rdy;
            exp_rdy = 1'b0;
            forever begin
                @(negedge clk);
                if (exp_rdy) begin
                    chk($sformatf("i%0d_ready_after_done", i), ready_w[i], 1);
                    chk($sformatf("i%0d_done_low_after", i), done_w[i], 0);
                    exp_rdy = 1'b0;
                end
                if (rst !== 1'b0 || valid_l[i] !== 1'b1 || ready_w[i] !== 1'b1) continue;
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("i%0d_unexpected_accept", i), 1, 0);
                    continue;
                end
                w   = exp_q[i].pop_front();
                seq = '0;
                np  = 0;
                for (int s = 0; s < 2; s++) begin seq[np] = 1'b0; np++; end
                for (int b = 0; b < 8; b++) begin seq[np] = w[b]; np++; end
                if (P == 1) begin seq[np] = ~^w; np++; end
                if (P == 2) begin seq[np] = ^w;  np++; end
                for (int s = 0; s < SB; s++) begin seq[np] = 1'b1; np++; end
                abort = 1'b0;
                for (int p = 0; p < np && !abort; p++) begin
                    for (int c = 0; c < CPB && !abort; c++) begin
                        @(negedge clk);
                        if (rst) begin
                            abort = 1'b1;
                        end else begin
                            chk($sformatf("i%0d_w%02h_tx_p%0d_c%0d", i, w, p, c), tx_w[i], seq[p]);
                            chk($sformatf("i%0d_busy_p%0d", i, p), busy_w[i], 1);
                        end
                    end
                end
                if (!abort) begin
                    @(negedge clk);
                    if (!rst) begin
                        chk($sformatf("i%0d_w%02h_done", i, w), done_w[i], 1);
                        chk($sformatf("i%0d_tx_in_done", i), tx_w[i], 1);
                        chk($sformatf("i%0d_ready_in_done", i), ready_w[i], 0);
                        exp_rdy = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d);
        int t;
        @(posedge clk); #2;
        data_l[i]  = d;
        valid_l[i] = 1'b1;
        exp_q[i].push_back(d);
        t = 0;
        do begin @(negedge clk); t++; end while (ready_w[i] !== 1'b1 && t < 300);
        if (t >= 300) chk($sformatf("i%0d_accept_timeout", i), 0, 1);
        @(posedge clk); #2;
        valid_l[i] = 1'b0;
        data_l[i]  = ~d;
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(ready_w[i] === 1'b1 && busy_w[i] === 1'b0) && t < 300);
        if (t >= 300) chk($sformatf("i%0d_idle_timeout", i), 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Negedges from acceptance until tx_done is seen.
    task automatic latency(input int i, input int exp_n);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (done_w[i] !== 1'b1 && n < 300);
        chk($sformatf("i%0d_done_latency", i), n, exp_n);
        @(negedge clk);
        chk($sformatf("i%0d_ready_latency", i), ready_w[i], 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dc;
        int n;
        rst     = 1'b1;
        valid_l = '0;
        for (int i = 0; i < 3; i++) data_l[i] = 8'h00;

        @(negedge clk);
        chk("rst_ready_low", ready_w[0], 0);

        // tx_valid raised while reset is still sampled high must not be taken.
        @(posedge clk); #2;
        valid_l[0] = 1'b1;
        data_l[0]  = 8'h77;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx_i%0d", i), tx_w[i], 1);
            chk($sformatf("rst_busy_i%0d", i), busy_w[i], 0);
            chk($sformatf("rst_done_i%0d", i), done_w[i], 0);
            chk($sformatf("rst_ready_i%0d", i), ready_w[i], 0);
        end
        @(posedge clk); #2;
        rst        = 1'b0;
        valid_l[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready_w[0], 1);
        @(negedge clk);
        chk("valid_at_rst_not_taken", busy_w[0], 0);

        // Default frame, 0xA5: done 12 cycles after acceptance.
        send(0, 8'hA5);
        latency(0, 12);
        wait_idle(0);

        // Odd parity on 0xA5: parity period (11th cycle) drives 1.
        send(1, 8'hA5);
        repeat (11) @(negedge clk);
        chk("odd_par_A5", tx_w[1], 1);
        wait_idle(1);

        // Even parity, 2 stop bits, 4 clks/bit.
        send(2, 8'hA5);
        n = 0;
        repeat (42) @(negedge clk);
        chk("even_par_A5", tx_w[2], 0);
        wait_idle(2);
        send(2, 8'h01);
        repeat (42) @(negedge clk);
        chk("even_par_01", tx_w[2], 1);
        wait_idle(2);
        send(2, 8'h3C);
        latency(2, 13 * 4 + 1);
        wait_idle(2);

        // Back-to-back with tx_valid held: three frames, three done pulses.
        dc = g_dut[0].done_cnt;
        @(posedge clk); #2;
        valid_l[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_l[0] = 8'(8'h11 * (k + 1));
            exp_q[0].push_back(data_l[0]);
            n = 0;
            do begin @(negedge clk); n++; end while (ready_w[0] !== 1'b1 && n < 300);
            if (n >= 300) chk("b2b_timeout", 0, 1);
            @(posedge clk); #2;
        end
        valid_l[0] = 1'b0;
        wait_idle(0);
        chk("b2b_done_pulses", g_dut[0].done_cnt - dc, 3);
        chk("b2b_queue_empty", exp_q[0].size(), 0);

        // Reset in the middle of a 0xFF frame.
        send(0, 8'hFF);
        repeat (4) @(negedge clk);
        dc = g_dut[0].done_cnt;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx_high", tx_w[0], 1);
        chk("abort_busy_low", busy_w[0], 0);
        chk("abort_done_low", done_w[0], 0);
        chk("abort_ready", ready_w[0], 1);
        repeat (20) @(negedge clk);
        chk("abort_no_done", g_dut[0].done_cnt - dc, 0);
        send(0, 8'h5A);
        wait_idle(0);

        // Random traffic through every configuration.
        for (int k = 0; k < 256; k++) begin
            send(0, 8'($urandom_range(0, 255)));
        end
        wait_idle(0);
        for (int k = 0; k < 32; k++) begin
            send(1, 8'($urandom_range(0, 255)));
            send(2, 8'($urandom_range(0, 255)));
        end
        wait_idle(1);
        wait_idle(2);

        for (int i = 0; i < 3; i++) chk($sformatf("final_queue_empty_i%0d", i), exp_q[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
